// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and load scoreboard for the register file's single write port.
// Optional forwarding outputs are enabled with `define WB_BYPASS_EN.
module rf_wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    input  logic [4:0]  dst,
    output logic        stall,
`ifdef WB_BYPASS_EN
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd_data,
`endif
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        rf_we
);

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    logic [2:0]  starve_q, starve_d;
    logic [31:0] pending_q, pending_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        rf_we_q, rf_we_d;
    logic        alu_force;
    logic        wb_hit1, wb_hit2;

    // The load normally wins; a starved ALU overrides it once the limit is reached.
    always_comb begin
        alu_force = alu_valid && (starve_q == STARVE_LIM);
        alu_ready = reset && alu_valid && (!ld_valid || alu_force);
        ld_ready  = reset && ld_valid && !alu_force;
    end

    always_comb begin
        starve_d = 3'd0;
        if (alu_valid && !alu_ready) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 3'd1;
        end
    end

    always_comb begin
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rf_we_d    = 1'b0;
        if (ld_valid && ld_ready) begin
            rf_waddr_d = ld_rd;
            rf_wdata_d = ld_data;
            rf_we_d    = (ld_rd != 5'd0);
        end else if (alu_valid && alu_ready) begin
            rf_waddr_d = alu_rd;
            rf_wdata_d = alu_data;
            rf_we_d    = (alu_rd != 5'd0);
        end
    end

    // Issue sets after the return clears, so a same-cycle re-issue keeps the bit.
    always_comb begin
        pending_d = pending_q;
        if (ld_valid && ld_ready) begin
            pending_d[ld_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q   <= 3'd0;
            pending_q  <= 32'd0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
            rf_we_q    <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            pending_q  <= pending_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_we_q    <= rf_we_d;
        end
    end

    // A write in flight is not yet visible in the register file this cycle.
    always_comb begin
        wb_hit1 = rf_we_q && (rf_waddr_q != 5'd0) && (rf_waddr_q == src1);
        wb_hit2 = rf_we_q && (rf_waddr_q != 5'd0) && (rf_waddr_q == src2);
`ifdef WB_BYPASS_EN
        stall    = pending_q[src1] || pending_q[src2] || pending_q[dst];
        fwd1_hit = wb_hit1;
        fwd2_hit = wb_hit2;
        fwd_data = rf_wdata_q;
`else
        stall    = pending_q[src1] || pending_q[src2] || pending_q[dst] ||
                   wb_hit1 || wb_hit2;
`endif
    end

    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign rf_we    = rf_we_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (STARVE_MAX = 4).
// Covers both builds; forwarding checks are compiled in with WB_BYPASS_EN.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, ld_valid, iss_valid;
    logic [4:0]  alu_rd, ld_rd, iss_rd, src1, src2, dst;
    logic [31:0] alu_data, ld_data;
    logic        alu_ready, ld_ready, stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_BYPASS_EN
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd_data;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .src1(src1), .src2(src2), .dst(dst), .stall(stall),
`ifdef WB_BYPASS_EN
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data),
`endif
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we)
    );

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
        alu_rd = 5'd0; ld_rd = 5'd0; iss_rd = 5'd0;
        alu_data = 32'd0; ld_data = 32'd0;
        src1 = 5'd0; src2 = 5'd0; dst = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        alu_valid = 1'b1; ld_valid = 1'b1; iss_valid = 1'b1;
        alu_rd = 5'd3; ld_rd = 5'd4; iss_rd = 5'd3;
        alu_data = 32'hAAAA_0001; ld_data = 32'hBBBB_0002;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_ready cyc%0d: alu_ready=%b ld_ready=%b, expected 0 0", i, alu_ready, ld_ready);
            end
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        src1 = 5'd3; src2 = 5'd4;
        #1;
        vectors++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_rf: we=%b waddr=%0d wdata=%h, expected 0 0 0", rf_we, rf_waddr, rf_wdata);
        end
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_stall: stall=%b, expected 0", stall);
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
        ld_valid  = 1'b1; ld_rd  = 5'd6; ld_data  = 32'h22;
        #1;
        vectors++;
        if (ld_ready !== 1'b1 || alu_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL simul_grant0: ld_ready=%b alu_ready=%b, expected 1 0", ld_ready, alu_ready);
        end
        tick();
        vectors++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h22) begin
            miscompares++;
            $display("[TB] FAIL simul_wb1: we=%b waddr=%0d wdata=%h, expected 1 6 00000022", rf_we, rf_waddr, rf_wdata);
        end
        ld_valid = 1'b0;
        #1;
        vectors++;
        if (alu_ready !== 1'b1 || ld_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL simul_grant1: alu_ready=%b ld_ready=%b, expected 1 0", alu_ready, ld_ready);
        end
        tick();
        vectors++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h11) begin
            miscompares++;
            $display("[TB] FAIL simul_wb2: we=%b waddr=%0d wdata=%h, expected 1 5 00000011", rf_we, rf_waddr, rf_wdata);
        end
        alu_valid = 1'b0;
        tick();
        vectors++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h11) begin
            miscompares++;
            $display("[TB] FAIL simul_hold: we=%b waddr=%0d wdata=%h, expected 0 5 00000011", rf_we, rf_waddr, rf_wdata);
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hA11;
        ld_valid  = 1'b1; ld_rd  = 5'd10; ld_data  = 32'hD10;
        for (int i = 0; i < 6; i++) begin
            logic exp_alu;
            exp_alu = (i == 4);
            #1;
            vectors++;
            if (alu_ready !== exp_alu || ld_ready !== !exp_alu) begin
                miscompares++;
                $display("[TB] FAIL starve_cyc%0d: alu_ready=%b ld_ready=%b, expected %b %b", i, alu_ready, ld_ready, exp_alu, !exp_alu);
            end
            tick();
            if (i == 4) begin
                vectors++;
                if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'hA11) begin
                    miscompares++;
                    $display("[TB] FAIL starve_wb: we=%b waddr=%0d wdata=%h, expected 1 11 00000a11", rf_we, rf_waddr, rf_wdata);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_x0();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        #1;
        vectors++;
        if (alu_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL x0_ready: alu_ready=%b, expected 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        vectors++;
        if (rf_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL x0_we: rf_we=%b, expected 0", rf_we);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_rd = 5'(12 + i);
            ld_data = 32'hC000_0000 + 32'(i);
            tick();
            vectors++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'(12 + i) || rf_wdata !== 32'hC000_0000 + 32'(i)) begin
                miscompares++;
                $display("[TB] FAIL b2b_%0d: we=%b waddr=%0d wdata=%h, expected 1 %0d %h", i, rf_we, rf_waddr, rf_wdata, 12 + i, 32'hC000_0000 + 32'(i));
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_scoreboard();
        src1 = 5'd7;
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sb_issue_cycle: stall=%b, expected 0", stall);
        end
        tick();
        iss_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) begin
                ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
            end
            #1;
            vectors++;
            if (stall !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL sb_wait_n%0d: stall=%b, expected 1", i, stall);
            end
            tick();
        end
        ld_valid = 1'b0;
        #1;
        vectors++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
            miscompares++;
            $display("[TB] FAIL sb_wb: we=%b waddr=%0d, expected 1 7", rf_we, rf_waddr);
        end
        vectors++;
`ifdef WB_BYPASS_EN
        if (stall !== 1'b0 || fwd1_hit !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sb_wb_stall: stall=%b fwd1_hit=%b, expected 0 1", stall, fwd1_hit);
        end
`else
        if (stall !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sb_wb_stall: stall=%b, expected 1", stall);
        end
`endif
        tick();
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sb_released: stall=%b, expected 0", stall);
        end

        // Same-cycle set and clear of x7: the set must win.
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b1; iss_rd = 5'd7;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h78;
        #1;
        vectors++;
        if (ld_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sb_same_ready: ld_ready=%b, expected 1", ld_ready);
        end
        tick();
        iss_valid = 1'b0; ld_valid = 1'b0;
        tick();
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sb_same_keep: stall=%b, expected 1", stall);
        end
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h79;
        tick();
        ld_valid = 1'b0;
        tick();
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sb_same_clear: stall=%b, expected 0", stall);
        end

        // Destination term guards against WAW on an outstanding load.
        src1 = 5'd0; dst = 5'd8;
        iss_valid = 1'b1; iss_rd = 5'd8;
        tick();
        iss_valid = 1'b0;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sb_dst: stall=%b, expected 1", stall);
        end
        ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 32'h88;
        tick();
        ld_valid = 1'b0;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sb_dst_clear: stall=%b, expected 0", stall);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_bypass();
        src2 = 5'd9;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h1234;
        tick();
        ld_valid = 1'b0;
        #1;
        vectors++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h1234) begin
            miscompares++;
            $display("[TB] FAIL byp_wb: we=%b waddr=%0d wdata=%h, expected 1 9 00001234", rf_we, rf_waddr, rf_wdata);
        end
        vectors++;
`ifdef WB_BYPASS_EN
        if (fwd2_hit !== 1'b1 || fwd1_hit !== 1'b0 || fwd_data !== 32'h1234 || stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL byp_fwd: fwd2=%b fwd1=%b data=%h stall=%b, expected 1 0 00001234 0", fwd2_hit, fwd1_hit, fwd_data, stall);
        end
`else
        if (stall !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL byp_stall: stall=%b, expected 1", stall);
        end
`endif
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAB;
        iss_valid = 1'b1; iss_rd = 5'd15;
        tick();
        idle_inputs();
        reset = 1'b0;
        vectors++;
        if (rf_we !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rmid_pre: rf_we=%b, expected 1", rf_we);
        end
        tick();
        reset = 1'b1;
        src1 = 5'd15;
        #1;
        vectors++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || stall !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rmid_post: we=%b waddr=%0d stall=%b, expected 0 0 0", rf_we, rf_waddr, stall);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        tick();
        test_reset();
        test_simultaneous();
        test_starvation();
        test_x0();
        test_back_to_back();
        test_scoreboard();
        test_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and load scoreboard for the 32x32 register file's single write port. Two requesters share the port: the single-cycle ALU result and the multi-cycle load return. The block grants one of them per cycle and registers the winner onto the register file write bus (write address, data, enable). It also keeps a pending-load bit per register, which it uses to generate the decode-stage stall.

## Interface
- STARVE_MAX, 4: consecutive cycles the ALU may be denied before it is forced to win; legal range 1..7.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = reset on the next rising edge)
- alu_valid  in  1  ALU write-back request
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- ld_valid  in  1  load-return write-back request
- ld_rd  in  5  load destination register
- ld_data  in  32  load data
- ld_ready  out  1  load request accepted this cycle
- iss_valid  in  1  a load is issued this cycle
- iss_rd  in  5  destination of the issued load
- src1, src2  in  5  each  decode-stage source registers
- dst  in  5  decode-stage destination register
- stall  out  1  decode must hold
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data
- rf_we  out  1  register file write enable

## Operation
- Handshake:
  - A request completes when valid && ready in the same cycle.
  - alu_ready and ld_ready are combinational. At most one of them is 1 in any cycle.
  - Both are 0 while reset == 0.
- Priority:
  - The load wins by default.
  - The ALU wins when only the ALU is valid.
  - The ALU also wins when both are valid and starve_cnt == STARVE_MAX.
- starve_cnt (3-bit):
  - Increments when alu_valid && !alu_ready.
  - Clears to 0 when the ALU is granted or alu_valid == 0.
  - Saturates at STARVE_MAX.
- Output stage:
  - On a granted handshake, the next rising edge loads rf_waddr/rf_wdata from the winner.
  - rf_we is set to 1 only if the winner's rd != 0.
  - x0 requests still complete the handshake but never write.
  - With no grant, rf_we goes to 0 and rf_waddr/rf_wdata hold their values.
- Scoreboard (pending[31:0]):
  - Set: iss_valid && iss_rd != 0 sets pending[iss_rd].
  - Clear: a load handshake clears pending[ld_rd].
  - Same register set and cleared in the same cycle: set wins.
  - pending[0] is always 0.
- stall is combinational. It is 1 if any of the following holds:
  - pending[src1], pending[src2] or pending[dst] (the dst term blocks WAW on an outstanding load).
  - rf_we && rf_waddr != 0 && rf_waddr equals src1 or src2 (the write lands only at the next edge).

## Timing
- Reset (reset == 0 at an edge):
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0, pending = 0, starve_cnt = 0.
  - stall = 0 after the reset edge.
- Reset mid-operation:
  - Discards the registered write. The register file sees rf_we = 0 on the next cycle.
  - Clears all pending bits. Requesters must re-present their requests.
- Latency:
  - Handshake at edge N: rf_we = 1 during cycle N+1.
  - The register file commits at edge N+2's launch edge (the edge ending cycle N+1).
  - The new value is readable from cycle N+2 onward.
- Throughput: one write per cycle, sustained.
- A load issued in cycle N raises stall for that register from cycle N+1.
- The clearing load write-back at edge M drops the pending bit in cycle M+1, but stall stays 1 through cycle M+1 via the rf_we compare.

## Configuration
- WB_BYPASS_EN defined:
  - Adds outputs fwd1_hit, fwd2_hit (1 bit each) and fwd_data (32 bits).
  - fwd1_hit = rf_we && rf_waddr != 0 && rf_waddr == src1; fwd2_hit likewise for src2.
  - fwd_data = rf_wdata.
  - The rf_we compare term is removed from stall. Only pending bits stall.
- WB_BYPASS_EN undefined: no forwarding ports; stall includes the rf_we compare as above.

## Test plan
- Reset:
  - Stimulus: reset = 0 for 2 cycles with alu_valid = ld_valid = iss_valid = 1.
  - Required: alu_ready = ld_ready = 0, rf_we = 0, stall = 0 after release, pending = 0.
- Simultaneous requests:
  - Stimulus: alu (rd 5, 0x11) and ld (rd 6, 0x22) both valid at cycle 0.
  - Required: ld granted at cycle 0, then rf_we = 1, rf_waddr = 6, rf_wdata = 0x22 at cycle 1; ALU granted at cycle 1, then rf_waddr = 5, rf_wdata = 0x11 at cycle 2.
- Starvation:
  - Stimulus: STARVE_MAX = 4; ld_valid held 1 continuously; alu_valid = 1 from cycle 0.
  - Required: ALU denied in cycles 0-3 and granted in cycle 4; ld_ready = 0 in cycle 4.
- x0:
  - Stimulus: alu rd 0, data 0xFFFF_FFFF.
  - Required: alu_ready = 1; rf_we stays 0 in the next cycle.
- Scoreboard:
  - Stimulus: iss_rd = 7; src1 = 7; ld returns rd 7 five cycles later.
  - Required: stall = 1 from the cycle after issue through the cycle rf_we writes x7 (the first cycle after pending[7] drops); stall = 0 the following cycle.
  - Same-cycle case: re-issue rd 7 in the ld handshake cycle. Required: pending[7] stays 1.
- Bypass:
  - Stimulus: with WB_BYPASS_EN, rf_we writes x9 = 0x1234 while src2 = 9.
  - Required: fwd2_hit = 1, fwd_data = 0x1234, stall = 0.
  - Without the macro, the same stimulus gives stall = 1.
